// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer: FSM state encoding and width.
// Build option COUNTDOWN_AUTORELOAD_EN is consumed by countdown_timer.
package countdown_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

endpackage

// File: rtl/press_edge.sv
// Rising-edge detector for a debounced, clk-synchronous button level.
// Shared by every button consumer in the clock.
module press_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_edge
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= i_level;
  end

  assign o_edge = i_level & ~r_prev;

endmodule

// File: rtl/countdown_timer.sv
// Run/pause/alarm countdown timer with bounded alarm duration.
// Define COUNTDOWN_AUTORELOAD_EN to reload and keep running on expiry.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH      = 17,
  parameter int ALARM_SECS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] init,
  input  logic             init_en,
  input  logic             onehz,
  input  logic             toggle_press,
  output logic [WIDTH-1:0] remain,
  output logic             running,
  output logic             alarm,
  output logic             done,
  output logic [1:0]       state
);

  localparam int CW =
    (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;
  localparam logic [CW-1:0] CNT_LD  = CW'(ALARM_SECS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] REM_ONE = WIDTH'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_remain, w_remain_nxt;
  logic [WIDTH-1:0] r_reload, w_reload_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_alarm, w_alarm_nxt;
  logic             r_done, w_done_nxt;
  logic             r_running;
  logic             w_edge;

  press_edge u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (toggle_press),
    .o_edge  (w_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_remain  <= '0;
      r_reload  <= '0;
      r_cnt     <= '0;
      r_alarm   <= 1'b0;
      r_done    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_remain  <= w_remain_nxt;
      r_reload  <= w_reload_nxt;
      r_cnt     <= w_cnt_nxt;
      r_alarm   <= w_alarm_nxt;
      r_done    <= w_done_nxt;
      r_running <= (w_state_nxt == RUN);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_reload_nxt = r_reload;
    w_cnt_nxt    = r_cnt;
    w_alarm_nxt  = r_alarm;
    w_done_nxt   = 1'b0;
    if (init_en) begin
      w_remain_nxt = init;
      w_reload_nxt = init;
      w_state_nxt  = IDLE;
      w_alarm_nxt  = 1'b0;
      w_cnt_nxt    = '0;
    end else if (w_edge) begin
      case (r_state)
        IDLE:  if (r_remain != '0) w_state_nxt = RUN;
        RUN: begin
          w_state_nxt = PAUSE;
`ifdef COUNTDOWN_AUTORELOAD_EN
          w_alarm_nxt = 1'b0;
          w_cnt_nxt   = '0;
`endif
        end
        PAUSE: w_state_nxt = RUN;
        ALARM: begin
          w_state_nxt = IDLE;
          w_alarm_nxt = 1'b0;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (onehz) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
      // background alarm timer; an expiry below restarts it
      if (r_cnt == CNT_ONE) begin
        w_cnt_nxt   = '0;
        w_alarm_nxt = 1'b0;
      end else if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - CNT_ONE;
      end
`endif
      case (r_state)
        RUN: begin
          if (r_remain > REM_ONE) begin
            w_remain_nxt = r_remain - REM_ONE;
          end else if (r_remain == REM_ONE) begin
            w_done_nxt  = 1'b1;
            w_alarm_nxt = 1'b1;
            w_cnt_nxt   = CNT_LD;
`ifdef COUNTDOWN_AUTORELOAD_EN
            w_remain_nxt = r_reload;
`else
            w_remain_nxt = '0;
            w_state_nxt  = ALARM;
`endif
          end
        end
        ALARM: begin
          if (r_cnt == CNT_ONE) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
            w_alarm_nxt = 1'b0;
          end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign remain  = r_remain;
  assign running = r_running;
  assign alarm   = r_alarm;
  assign done    = r_done;
  assign state   = r_state;

endmodule
